inst_boot_loader: RTL

//  Upstream feeder for the instruction BRAM: takes a byte stream (UART RX or

---
 rtl/inst_boot_loader_if.sv | 26 ++
 rtl/inst_boot_loader.sv | 133 +++++++++++++
 2 files changed

// File: rtl/inst_boot_loader_if.sv
// Byte-stream input and instruction-BRAM write port of the boot loader.
// The loader sits on the slave side; the byte source and the BRAM side use master.
interface inst_boot_loader_if #(
    parameter int W = 32
) ();
    logic         start;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         is_write;
    logic [W-1:0] im_addr;
    logic [W-1:0] im_inst;
    logic         core_rst;
    logic         done;
    logic         err;

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, is_write, im_addr, im_inst, core_rst, done, err
    );

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, is_write, im_addr, im_inst, core_rst, done, err
    );
endinterface

// File: rtl/inst_boot_loader.sv
// Loads a length-prefixed little-endian word image from a byte stream into the
// instruction BRAM and holds the core in reset until the whole image is written.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// LEN   | collecting the 4-byte word count N
// DATA  | collecting the 4 bytes of the next word
// WRITE | single-cycle BRAM write of the assembled word
// DONE  | image loaded, core released
// ERR   | bad length or inter-byte timeout, core held in reset
module inst_boot_loader #(
    parameter int W       = 32,
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_boot_loader_if.slave    bus
);
    localparam int IW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

    state_t         state, state_nxt;
    logic [1:0]     cnt;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  timer;
    logic [W-9:0]   len_lo;
    logic [W-9:0]   word;
    logic [W-1:0]   len;
    logic [W-1:0]   im_addr, im_inst;
    logic [W-1:0]   n_new;
    logic           rx_ready, is_write, hs, timed_out;

    // Bytes enter at the top and shift down, so byte k ends up at bits [8k+7:8k].
    assign n_new     = {bus.rx_data, len_lo};
    assign hs        = bus.rx_valid && (state == LEN || state == DATA);
    assign timed_out = (timer == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        is_write  = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = LEN;
            LEN: begin
                rx_ready = 1'b1;
                if (hs) begin
                    if (cnt == 2'd3)
                        state_nxt = (n_new == '0 || n_new > W'(DEPTH)) ? ERR : DATA;
                end else if (timed_out) begin
                    state_nxt = ERR;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (hs) begin
                    if (cnt == 2'd3) state_nxt = WRITE;
                end else if (timed_out) begin
                    state_nxt = ERR;
                end
            end
            WRITE: begin
                is_write  = 1'b1;
                state_nxt = (W'(idx) == len - W'(1)) ? DONE : DATA;
            end
            DONE, ERR: if (bus.start) state_nxt = LEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            timer   <= '0;
            len_lo  <= '0;
            word    <= '0;
            len     <= '0;
            im_addr <= '0;
            im_inst <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        cnt   <= '0;
                        idx   <= '0;
                        timer <= '0;
                    end
                end
                LEN: begin
                    if (hs) begin
                        timer  <= '0;
                        cnt    <= cnt + 2'd1;
                        len_lo <= {bus.rx_data, len_lo[W-9:8]};
                        if (cnt == 2'd3) len <= n_new;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (hs) begin
                        timer <= '0;
                        cnt   <= cnt + 2'd1;
                        word  <= {bus.rx_data, word[W-9:8]};
                        if (cnt == 2'd3) begin
                            im_inst <= {bus.rx_data, word};
                            im_addr <= W'(idx) << 2;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WRITE: idx <= idx + IW'(1);
                default: ;
            endcase
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.is_write = is_write;
    assign bus.im_addr  = im_addr;
    assign bus.im_inst  = im_inst;
    assign bus.done     = (state == DONE);
    assign bus.err      = (state == ERR);
    assign bus.core_rst = (state != DONE);
endmodule
